mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read unified memory between the core's instruction-fetch port and its load/store port. It sits between the 32-bit pipelined core (fetch unit and LSU sides) and the SoC memory macro. Each requester gets a 4-cycle request/acknowledge handshake, and grants go through a data-priority FSM. A starvation counter prevents the fetch port from being locked out by long load/store bursts.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_fair_pick.sv | 55 +++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_fair_pick.sv
// Winner selection between fetch and data requests, with the data-streak
// counter that forces a fetch grant after STARVE_MAX contended data grants.
module arb_fair_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant,
  output logic pick_d
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] streak_r;
  logic [SW-1:0] streak_next_s;

  // Data wins unless fetch is also waiting and the streak has hit its limit.
  always_comb begin
    pick_d = 1'b0;
    if (d_req && !(if_req && (streak_r == SMAX))) begin
      pick_d = 1'b1;
    end else begin
      pick_d = 1'b0;
    end
  end

  // Streak only moves when a grant is actually made.
  always_comb begin
    streak_next_s = streak_r;
    if (grant) begin
      if (!pick_d) begin
        streak_next_s = '0;
      end else if (if_req && (streak_r != SMAX)) begin
        streak_next_s = streak_r + {{(SW-1){1'b0}}, 1'b1};
      end else begin
        streak_next_s = streak_r;
      end
    end else begin
      streak_next_s = streak_r;
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_r <= '0;
    end else begin
      streak_r <= streak_next_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous-read memory between the fetch and
// load/store ports using a fixed four-phase access sequence.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e state_r;
  state_e state_next_s;
  owner_e owner_r;
  logic   wr_r;
  logic   grant_s;
  logic   pick_d_s;

  assign grant_s = (state_r == IDLE) && (if_req || d_req);

  arb_fair_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .grant  (grant_s),
    .pick_d (pick_d_s)
  );

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_next_s = ACC;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACC:     state_next_s = RSP;
      RSP:     state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: memory strobes, captured read data and ack pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r   <= OWN_IF;
      wr_r      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
      if_rdata  <= {DW{1'b0}};
      d_rdata   <= {DW{1'b0}};
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            mem_en <= 1'b1;
            if (pick_d_s) begin
              owner_r   <= OWN_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              wr_r      <= |d_we;
            end else begin
              owner_r  <= OWN_IF;
              mem_we   <= 4'b0000;
              mem_addr <= if_addr;
              wr_r     <= 1'b0;
            end
          end
        end
        ACC: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
        end
        RSP: begin
          // Memory data is valid now; only reads update the owner's rdata.
          if (owner_r == OWN_D) begin
            d_ack <= 1'b1;
            if (!wr_r) begin
              d_rdata <= mem_rdata;
            end
          end else begin
            if_ack <= 1'b1;
            if (!wr_r) begin
              if_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed and
// randomized requester traffic against a behavioural memory macro.
module tb_mem_arbiter;

  localparam int SMAX = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.STARVE_MAX(SMAX), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Memory macro seen by the DUT, and the model's private copy of memory.
  logic [31:0] mac [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= mac[mem_addr[9:2]];
      else mac[mem_addr[9:2]] <= merge(mac[mem_addr[9:2]], mem_wdata, mem_we);
    end
  end

  // Reference model: a grant opens a 3-cycle window (age 1..3) after which
  // the port is free again; age 1 is the memory access, age 3 the ack cycle.
  int          age;
  int          streak;
  logic        m_own_d;
  logic [31:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdata;
  logic [31:0] e_if_rdata;
  logic [31:0] e_d_rdata;
  logic        grant_log [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0; streak = 0; m_own_d = 1'b0; m_addr = 32'h0; m_we = 4'h0;
      m_wdata = 32'h0; e_if_rdata = 32'h0; e_d_rdata = 32'h0;
    end else if (age == 0) begin
      if (if_req || d_req) begin
        m_own_d = d_req && !(if_req && streak == SMAX);
        grant_log.push_back(m_own_d);
        if (m_own_d) begin
          m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          if (if_req && streak < SMAX) streak++;
        end else begin
          m_addr = if_addr; m_we = 4'h0; streak = 0;
        end
        age = 1;
      end
    end else begin
      if (age == 1 && m_we != 4'h0)
        ref_mem[m_addr[9:2]] = merge(ref_mem[m_addr[9:2]], m_wdata, m_we);
      if (age == 2 && m_we == 4'h0) begin
        if (m_own_d) e_d_rdata = ref_mem[m_addr[9:2]];
        else e_if_rdata = ref_mem[m_addr[9:2]];
      end
      age = (age == 3) ? 0 : age + 1;
    end
  end

  // Cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_en", {31'h0, mem_en}, {31'h0, age == 1});
      chk("mem_we", {28'h0, mem_we}, (age == 1) ? {28'h0, m_we} : 32'h0);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_ack", {31'h0, if_ack}, {31'h0, age == 3 && !m_own_d});
      chk("d_ack", {31'h0, d_ack}, {31'h0, age == 3 && m_own_d});
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a;
  endfunction

  logic ia;
  logic da;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mac[i] = $urandom;
      ref_mem[i] = mac[i];
    end
    mac[64] = 32'h0000_0013;
    ref_mem[64] = 32'h0000_0013;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fetch read
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("fr_en", {31'h0, mem_en}, 32'h1);
    chk("fr_addr", mem_addr, 32'h100);
    chk("fr_we", {28'h0, mem_we}, 32'h0);
    repeat (2) @(negedge clk);
    chk("fr_ack", {31'h0, if_ack}, 32'h1);
    chk("fr_rdata", if_rdata, 32'h0000_0013);
    @(posedge clk); #1 if_req = 1'b0;

    // Word store
    d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("ws_we", {28'h0, mem_we}, 32'hF);
    chk("ws_wdata", mem_wdata, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    chk("ws_ack", {31'h0, d_ack}, 32'h1);
    chk("ws_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 d_req = 1'b0;

    // Byte store
    d_req = 1'b1; d_we = 4'b0010; d_addr = 32'h2004; d_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    chk("bs_we_acc", {28'h0, mem_we}, 32'h2);
    @(negedge clk);
    chk("bs_we_rsp", {28'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("bs_we_done", {28'h0, mem_we}, 32'h0);
    chk("bs_ack", {31'h0, d_ack}, 32'h1);
    @(posedge clk); #1 d_req = 1'b0;

    // Contention with both requests held
    grant_log.delete();
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 4'h0; d_addr = 32'h800;
    @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      chk("ct_addr", mem_addr, (g % 3 != 2) ? 32'h800 : 32'h400);
      if (g < 5) repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    chk("ct_ngrants", grant_log.size(), 32'd6);
    for (int g = 0; g < 6 && g < grant_log.size(); g++)
      chk("ct_order", {31'h0, grant_log[g]}, (g % 3 != 2) ? 32'h1 : 32'h0);
    chk("ct_streak_model", streak, 32'h0);
    chk("ct_streak_dut", {30'h0, dut.u_pick.streak_r}, 32'h0);

    // Back-to-back fetch
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("bb_ack1", {31'h0, if_ack}, 32'h1);
    @(negedge clk);
    chk("bb_en_gap", {31'h0, mem_en}, 32'h0);
    @(negedge clk);
    chk("bb_en2", {31'h0, mem_en}, 32'h1);
    repeat (2) @(negedge clk);
    chk("bb_ack2", {31'h0, if_ack}, 32'h1);
    @(posedge clk); #1 if_req = 1'b0;

    // Reset during ACC of a data read
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    chk("rm_en_acc", {31'h0, mem_en}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rm_en_rst", {31'h0, mem_en}, 32'h0);
    chk("rm_addr_rst", mem_addr, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rm_en_rel", {31'h0, mem_en}, 32'h0);
    chk("rm_noack", {31'h0, d_ack}, 32'h0);
    @(negedge clk);
    chk("rm_en_rel2", {31'h0, mem_en}, 32'h1);
    chk("rm_addr_rel2", mem_addr, 32'h500);
    repeat (2) @(negedge clk);
    chk("rm_ack", {31'h0, d_ack}, 32'h1);
    @(posedge clk); #1 d_req = 1'b0;

    // Randomized traffic, requests held until their ack
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ia = if_ack; da = d_ack;
      @(posedge clk); #1;
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = rand_addr(); end
      end else if (ia) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_addr = rand_addr();
      end
      if (!d_req) begin
        if ($urandom_range(0, 1) == 0) begin
          d_req = 1'b1; d_addr = rand_addr(); d_wdata = $urandom;
          d_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end
      end else if (da) begin
        if ($urandom_range(0, 2) == 0) d_req = 1'b0;
        else begin
          d_addr = rand_addr(); d_wdata = $urandom;
          d_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("end_streak_range", {31'h0, dut.u_pick.streak_r <= SMAX}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
